// File: rtl/sched_pkg.sv
// Shared scheduler definitions: issue FSM encoding, command direction constants,
// default DDR5 spacing values and the spacing-selection helper.
package sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_POP  = 2'd2,
      ST_WAIT = 2'd3
   } sched_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   localparam int unsigned DEF_Q_MAX = 32'd8;
   localparam int unsigned DEF_T_CCD = 32'd4;
   localparam int unsigned DEF_T_WTR = 32'd6;
   localparam int unsigned DEF_T_RTW = 32'd3;
   localparam int unsigned DEF_CW    = 32'd8;

   function automatic int unsigned gap_cycles(input logic        last_rw,
                                              input logic        next_rw,
                                              input int unsigned t_ccd,
                                              input int unsigned t_wtr,
                                              input int unsigned t_rtw);
      int unsigned g;
      if (last_rw == next_rw) begin
         g = t_ccd;
      end else if (last_rw == RW_WRITE && next_rw == RW_READ) begin
         g = t_wtr;
      end else begin
         g = t_rtw;
      end
      return g;
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sched_gap_timer.sv
// Spacing timer: tracks cycles since the last handshake and counts down the
// remaining gap; a re-target always measures from the handshake cycle.
module sched_gap_timer #(
   parameter int unsigned GW = 32'd4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          load_i,
   input  logic [GW-1:0] load_val_i,
   input  logic          ext_i,
   input  logic [GW-1:0] ext_val_i,
   output logic          done_o,
   output logic [GW-1:0] elapsed_o
);

   logic [GW-1:0] el_q, el_d;
   logic [GW-1:0] rem_q, rem_d;
   logic [GW-1:0] tgt_s;

   // Saturating count of cycles since the handshake
   always_comb begin
      if (start_i) begin
         el_d = {{(GW-1){1'b0}}, 1'b1};
      end else if (el_q == {GW{1'b1}}) begin
         el_d = el_q;
      end else begin
         el_d = el_q + {{(GW-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      if (ext_i) begin
         tgt_s = ext_val_i;
      end else begin
         tgt_s = load_val_i;
      end
      if (load_i || ext_i) begin
         if (tgt_s > el_d) begin
            rem_d = tgt_s - el_d;
         end else begin
            rem_d = {GW{1'b0}};
         end
      end else if (rem_q != {GW{1'b0}}) begin
         rem_d = rem_q - {{(GW-1){1'b0}}, 1'b1};
      end else begin
         rem_d = rem_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         el_q  <= {GW{1'b0}};
         rem_q <= {GW{1'b0}};
      end else begin
         el_q  <= el_d;
         rem_q <= rem_d;
      end
   end

   assign done_o    = (rem_q == {GW{1'b0}});
   assign elapsed_o = el_q;

endmodule

// File: rtl/sched_issue_ctrl.sv
// Issue end of the scheduler queue: presents the head command with valid/ready,
// pops the queue once per accepted command and enforces tCCD/tWTR/tRTW spacing.
module sched_issue_ctrl
   import sched_pkg::*;
#(
   parameter int unsigned Q_MAX = DEF_Q_MAX,
   parameter int unsigned T_CCD = DEF_T_CCD,
   parameter int unsigned T_WTR = DEF_T_WTR,
   parameter int unsigned T_RTW = DEF_T_RTW,
   parameter int unsigned CW    = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in_q,
   input  logic          rw_in_q,
   input  logic          cmd_ready,
   output logic          cmd_valid,
   output logic          cmd_rw,
   output logic          sh_en,
   output logic [CW-1:0] issue_cnt,
   output logic          busy,
   output logic          err
);

   localparam int unsigned T_MAX = max3(T_CCD, T_WTR, T_RTW);
   localparam int unsigned GW    = $clog2(T_MAX) + 32'd1;

   if (Q_MAX < 32'd1 || T_CCD < 32'd1 || T_WTR < 32'd1 || T_RTW < 32'd1 || CW < 32'd1) begin : g_bad_param
      $error("sched_issue_ctrl: depth, timing and counter parameters must be >= 1");
   end

   sched_state_e  state_q, state_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          cmd_rw_q, cmd_rw_d;
   logic          sh_en_q, sh_en_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          last_rw_q, last_rw_d;
   logic          first_cmd_q, first_cmd_d;
   logic [CW-1:0] issue_cnt_q, issue_cnt_d;

   logic          hs_s;
   logic          dir_ok_s;
   logic          tmr_load_s, tmr_ext_s, tmr_done_s;
   logic [GW-1:0] req_gap_s, pop_gap_s, elapsed_s;

   assign hs_s = cmd_valid_q & cmd_ready;

   // POP assumes the pending head; an empty queue falls back to same-direction spacing
   always_comb begin
      req_gap_s = GW'(gap_cycles(last_rw_q, rw_in_q, T_CCD, T_WTR, T_RTW));
      if (valid_in_q) begin
         pop_gap_s = req_gap_s;
      end else begin
         pop_gap_s = GW'(T_CCD);
      end
      if (first_cmd_q) begin
         dir_ok_s = 1'b1;
      end else if (elapsed_s >= req_gap_s) begin
         dir_ok_s = 1'b1;
      end else begin
         dir_ok_s = 1'b0;
      end
   end

   sched_gap_timer #(
      .GW(GW)
   ) u_gap_timer (
      .clk_i      (clk),
      .rst_ni     (rst),
      .start_i    (hs_s),
      .load_i     (tmr_load_s),
      .load_val_i (pop_gap_s),
      .ext_i      (tmr_ext_s),
      .ext_val_i  (req_gap_s),
      .done_o     (tmr_done_s),
      .elapsed_o  (elapsed_s)
   );

   // Next state; outputs are registered from the next state so they align with it
   always_comb begin
      state_d     = state_q;
      tmr_load_s  = 1'b0;
      tmr_ext_s   = 1'b0;
      cmd_rw_d    = cmd_rw_q;
      last_rw_d   = last_rw_q;
      first_cmd_d = first_cmd_q;
      issue_cnt_d = issue_cnt_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (!valid_in_q) begin
               state_d = ST_IDLE;
            end else if (dir_ok_s) begin
               state_d  = ST_REQ;
               cmd_rw_d = rw_in_q;
            end else begin
               state_d   = ST_WAIT;
               tmr_ext_s = 1'b1;
            end
         end
         ST_REQ: begin
            if (!valid_in_q) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (hs_s) begin
               state_d     = ST_POP;
               last_rw_d   = cmd_rw_q;
               first_cmd_d = 1'b0;
               issue_cnt_d = issue_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_POP: begin
            state_d    = ST_WAIT;
            tmr_load_s = 1'b1;
         end
         ST_WAIT: begin
            if (!tmr_done_s) begin
               state_d = ST_WAIT;
            end else if (!valid_in_q) begin
               state_d = ST_IDLE;
            end else if (dir_ok_s) begin
               state_d  = ST_REQ;
               cmd_rw_d = rw_in_q;
            end else begin
               state_d   = ST_WAIT;
               tmr_ext_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cmd_valid_d = (state_d == ST_REQ);
      sh_en_d     = (state_d == ST_POP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cmd_valid_q <= 1'b0;
         cmd_rw_q    <= 1'b0;
         sh_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         last_rw_q   <= 1'b0;
         first_cmd_q <= 1'b1;
         issue_cnt_q <= {CW{1'b0}};
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_rw_q    <= cmd_rw_d;
         sh_en_q     <= sh_en_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         last_rw_q   <= last_rw_d;
         first_cmd_q <= first_cmd_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_rw    = cmd_rw_q;
   assign sh_en     = sh_en_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_sched_issue_ctrl.sv
// Bench for sched_issue_ctrl: per-cycle vector table (inputs + expected outputs)
// followed by a 256-handshake counter-wrap run.
module tb_sched_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_in_q;
   logic       rw_in_q;
   logic       cmd_ready;
   logic       cmd_valid;
   logic       cmd_rw;
   logic       sh_en;
   logic [7:0] issue_cnt;
   logic       busy;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_sh  = 0;

   typedef struct {
      logic       r, v, rw, rd;
      logic       cv, erw, sh, bz, er;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   sched_issue_ctrl #(
      .Q_MAX(8), .T_CCD(4), .T_WTR(6), .T_RTW(3), .CW(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in_q (valid_in_q),
      .rw_in_q    (rw_in_q),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_rw     (cmd_rw),
      .sh_en      (sh_en),
      .issue_cnt  (issue_cnt),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic v, input logic rw, input logic rd,
                               input logic cv, input logic erw, input logic sh,
                               input logic bz, input logic er, input int cnt);
      vec_t e;
      e.r = r; e.v = v; e.rw = rw; e.rd = rd;
      e.cv = cv; e.erw = erw; e.sh = sh; e.bz = bz; e.er = er;
      e.cnt = 8'(cnt);
      tbl.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [12:0] act_v, exp_v;

      // rst v rw rdy | cmd_valid cmd_rw sh_en busy err issue_cnt
      // single read, ready high
      add(0,0,0,1, 0,0,0,0,0,0);
      add(0,0,0,1, 0,0,0,0,0,0);
      add(1,1,0,1, 0,0,0,0,0,0);
      add(1,1,0,1, 1,0,0,1,0,0);
      add(1,0,0,1, 0,0,1,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,0,0,1, 0,0,0,0,0,1);
      // back-to-back reads: handshakes 1, 6, 11
      add(0,0,0,1, 0,0,0,0,0,0);
      add(1,1,0,1, 0,0,0,0,0,0);
      add(1,1,0,1, 1,0,0,1,0,0);
      add(1,1,0,1, 0,0,1,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 1,0,0,1,0,1);
      add(1,1,0,1, 0,0,1,1,0,2);
      add(1,1,0,1, 0,0,0,1,0,2);
      add(1,1,0,1, 0,0,0,1,0,2);
      add(1,1,0,1, 0,0,0,1,0,2);
      add(1,1,0,1, 1,0,0,1,0,2);
      add(1,0,0,1, 0,0,1,1,0,3);
      add(1,0,0,1, 0,0,0,1,0,3);
      // reset mid-WAIT, then a write issues with no turnaround
      add(0,0,0,1, 0,0,0,0,0,0);
      add(1,1,1,1, 0,0,0,0,0,0);
      add(1,1,1,1, 1,1,0,1,0,0);
      // write -> read: next cmd_valid at n+7
      add(1,1,0,1, 0,0,1,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 1,0,0,1,0,1);
      // read -> write: next cmd_valid at n+4, then 5 cycles of backpressure
      add(1,1,1,1, 0,0,1,1,0,2);
      add(1,1,1,1, 0,0,0,1,0,2);
      add(1,1,1,1, 0,0,0,1,0,2);
      add(1,1,1,0, 1,1,0,1,0,2);
      add(1,1,1,0, 1,1,0,1,0,2);
      add(1,1,0,0, 1,1,0,1,0,2);
      add(1,1,0,0, 1,1,0,1,0,2);
      add(1,1,1,0, 1,1,0,1,0,2);
      add(1,1,1,1, 1,1,0,1,0,2);
      // empty at POP, read arrives in WAIT: gap stretched to tWTR from the write
      add(1,0,0,1, 0,0,1,1,0,3);
      add(1,1,0,1, 0,0,0,1,0,3);
      add(1,1,0,1, 0,0,0,1,0,3);
      add(1,1,0,1, 0,0,0,1,0,3);
      add(1,1,0,1, 0,0,0,1,0,3);
      add(1,1,0,1, 0,0,0,1,0,3);
      // valid drops in REQ: sticky err, request kept
      add(1,1,0,0, 1,0,0,1,0,3);
      add(1,0,0,0, 1,0,0,1,0,3);
      add(1,1,0,1, 1,0,0,1,1,3);
      add(1,0,0,1, 0,0,1,1,1,4);
      add(1,0,0,1, 0,0,0,1,1,4);
      add(1,0,0,1, 0,0,0,1,1,4);
      add(1,0,0,1, 0,0,0,1,1,4);
      add(1,0,0,1, 0,0,0,0,1,4);
      add(0,0,0,1, 0,0,0,0,0,0);
      // reset while in REQ: no pop afterwards
      add(1,1,0,1, 0,0,0,0,0,0);
      add(0,1,0,1, 0,0,0,0,0,0);
      add(1,0,0,1, 0,0,0,0,0,0);
      add(1,0,0,1, 0,0,0,0,0,0);
      // write, queue empties, read arrives after IDLE: still spaced n+7
      add(1,1,1,1, 0,0,0,0,0,0);
      add(1,1,1,1, 1,1,0,1,0,0);
      add(1,0,0,1, 0,0,1,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,0,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 0,0,0,0,0,1);
      add(1,1,0,1, 0,0,0,1,0,1);
      add(1,1,0,1, 1,0,0,1,0,1);
      add(1,0,0,1, 0,0,1,1,0,2);

      rst = 1'b0; valid_in_q = 1'b0; rw_in_q = 1'b0; cmd_ready = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst        = tbl[i].r;
         valid_in_q = tbl[i].v;
         rw_in_q    = tbl[i].rw;
         cmd_ready  = tbl[i].rd;
         #1;
         act_v = {cmd_valid, (tbl[i].cv ? cmd_rw : 1'b0), sh_en, busy, err, issue_cnt};
         exp_v = {tbl[i].cv, (tbl[i].cv ? tbl[i].erw : 1'b0), tbl[i].sh, tbl[i].bz,
                  tbl[i].er, tbl[i].cnt};
         check($sformatf("vec%0d {cv,rw,sh,busy,err,cnt}", i), 32'(act_v), 32'(exp_v));
      end

      // 256 back-to-back reads: handshakes at 1+5k, pops at 2+5k, count wraps to 0
      @(negedge clk);
      rst = 1'b0; valid_in_q = 1'b0; cmd_ready = 1'b1;
      #1;
      check("wrap_reset_cnt", 32'(issue_cnt), 32'd0);
      for (int c = 0; c <= 1277; c++) begin
         @(negedge clk);
         rst        = 1'b1;
         valid_in_q = (c <= 1276);
         rw_in_q    = 1'b0;
         cmd_ready  = 1'b1;
         #1;
         check($sformatf("wrap_sh_en@%0d", c), 32'(sh_en), 32'((c >= 2) && (c % 5 == 2)));
         if (sh_en) n_sh++;
         if (c == 1272) check("wrap_cnt_255", 32'(issue_cnt), 32'd255);
         if (c == 1277) check("wrap_cnt_0", 32'(issue_cnt), 32'd0);
      end
      check("wrap_pop_pulses", 32'(n_sh), 32'd256);
      check("wrap_err", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sched_issue_ctrl.md
Name: sched_issue_ctrl

Overview:
Drain/issue end of the per-channel scheduler queue. It watches the queue head (valid_in_q, rw_in_q) and presents the head command to the DDR5 command path with a valid/ready handshake. After each accepted command it pulses sh_en so the queue shifts exactly once. It also enforces same-direction spacing (tCCD) and read/write turnaround (tWTR, tRTW) between issued commands.

Parameters:
Q_MAX, 8, queue depth of the companion scheduler chain; informational only, no logic depends on it.
T_CCD, 4, minimum cycles between handshakes of same-direction commands; must be >= 1.
T_WTR, 6, minimum cycles from a write handshake to the next read handshake; must be >= 1.
T_RTW, 3, minimum cycles from a read handshake to the next write handshake; must be >= 1.
CW, 8, width of the issue counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-low.
valid_in_q  input  1  queue head holds a valid command.
rw_in_q  input  1  head direction: 1 = write, 0 = read.
cmd_ready  input  1  command path accepts the presented command.
cmd_valid  output  1  command presented to the command path.
cmd_rw  output  1  direction of the presented command.
sh_en  output  1  one-cycle pop pulse to the queue.
issue_cnt  output  CW  count of accepted commands; wraps modulo 2^CW.
busy  output  1  high in any state other than IDLE.
err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; cmd_valid, cmd_rw, sh_en, busy, err and issue_cnt = 0; gap counter = 0; first_cmd = 1.
- FSM states: IDLE, REQ, POP, WAIT.
- IDLE -> REQ on the cycle after valid_in_q is sampled high. In REQ, cmd_valid = 1 and cmd_rw = the rw_in_q value captured on entry to REQ.
- REQ: cmd_valid and cmd_rw are held stable until cmd_valid & cmd_ready. The command is never withdrawn.
- If valid_in_q falls while in REQ, set err (sticky until reset) and keep the request asserted.
- Handshake at cycle n:
  - At cycle n, last_rw <= cmd_rw, first_cmd <= 0, issue_cnt increments.
  - Cycle n+1 is POP: sh_en = 1 for exactly that cycle and cmd_valid = 0.
  - Gap G is selected in POP by comparing the head direction still pending with last_rw:
    - same direction, or queue empty: G = T_CCD;
    - last = write, next = read: G = T_WTR;
    - last = read, next = write: G = T_RTW.
  - Direction is re-evaluated at the next REQ entry. If that direction differs from the one G assumed, the remaining gap is extended to the correct turnaround, measured from cycle n.
- Spacing rule: the earliest next cmd_valid is cycle n + 1 + G. In WAIT, the counter decrements each cycle; cmd_valid stays 0 and sh_en stays 0.
- Leaving WAIT: go to IDLE when the counter expires. Go directly to REQ if valid_in_q is high that cycle.
- The first command after reset ignores turnaround, because first_cmd = 1.
- busy = 1 in REQ, POP and WAIT.
- Never more than one sh_en pulse per handshake. sh_en is never asserted without a preceding handshake.
- cmd_ready while cmd_valid = 0 is ignored.
- Counter width = $clog2(max(T_CCD, T_WTR, T_RTW)) + 1.
- Reset asserted mid-handshake or mid-WAIT: all outputs drop immediately. No pop is generated for a command still in REQ.

Decomposition:
- Shared package sched_pkg: state encoding for IDLE/REQ/POP/WAIT, the RW_WRITE = 1 and RW_READ = 0 constants, and default timing constants, reused by the queue chain and the arbiter.
- One natural sub-module: sched_gap_timer. It loads G, counts down, provides a done output, and handles the extend-on-direction-change request.

Test Plan:
- Single read, cmd_ready tied high:
  - valid_in_q = 1, rw_in_q = 0 at cycle 0 gives cmd_valid at cycle 1 and a handshake at cycle 1.
  - sh_en is high only at cycle 2; issue_cnt = 1.
- Back-to-back reads with valid_in_q held high and cmd_ready high: handshakes at cycles 1, 6, 11 (spacing T_CCD + 1 = 5 with defaults).
- Write then read: write handshake at cycle n gives the next cmd_valid no earlier than n + 7 (T_WTR = 6). Read then write gives n + 4 (T_RTW = 3).
- Backpressure: cmd_ready low for 5 cycles while in REQ.
  - cmd_valid and cmd_rw stay stable and sh_en stays 0.
  - When cmd_ready rises, exactly one sh_en pulse follows.
- Protocol error and wrap:
  - Dropping valid_in_q during REQ sets err = 1, which holds until rst goes low.
  - 256 handshakes wrap issue_cnt from 255 to 0.
- Reset mid-WAIT: pulsing rst low drops busy and sh_en immediately. The next command after release issues with no turnaround delay.
